// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
// fetch_queue: fetch PC register plus a DEPTH-entry {pc, instr} FIFO drained by decode.
// Define FETCH_BYPASS_EN to forward an imem response to decode in the same cycle when empty.
module fetch_queue #(
  parameter int              PC_W    = 32,
  parameter int              INSTR_W = 32,
  parameter int              DEPTH   = 4,
  parameter logic [PC_W-1:0] PC_INIT = '0
) (
  input  logic                         CLK,
  input  logic                         RST,
  output logic                         imem_req,
  output logic [PC_W-1:0]              imem_addr,
  input  logic                         ihit,
  input  logic [INSTR_W-1:0]           imemload,
  input  logic [PC_W-1:0]              pc_prediction,
  input  logic                         misprediction,
  input  logic [PC_W-1:0]              correct_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              out_pc,
  output logic [INSTR_W-1:0]           out_instr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PC_W-1:0]    r_fetch_pc;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [PC_W-1:0]    r_pc_mem    [DEPTH];
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_bypass;
  logic w_byp_take;
  logic w_wr;
  logic w_rd;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign imem_req  = !w_full || out_ready;
  assign imem_addr = r_fetch_pc;
  assign count     = r_count;
  assign w_push    = ihit && imem_req && !misprediction;

`ifdef FETCH_BYPASS_EN
  // An empty queue forwards the live response; it is only stored if decode stalls.
  assign w_bypass   = w_empty && w_push;
  assign w_byp_take = w_bypass && out_ready;
  assign out_valid  = !w_empty || w_bypass;
  assign out_pc     = w_bypass ? r_fetch_pc : r_pc_mem[r_rd_ptr];
  assign out_instr  = w_bypass ? imemload   : r_instr_mem[r_rd_ptr];
`else
  assign w_bypass   = 1'b0;
  assign w_byp_take = 1'b0;
  assign out_valid  = !w_empty;
  assign out_pc     = r_pc_mem[r_rd_ptr];
  assign out_instr  = r_instr_mem[r_rd_ptr];
`endif

  assign w_pop = out_valid && out_ready;
  assign w_wr  = w_push && !w_byp_take;
  assign w_rd  = w_pop && !w_byp_take && !misprediction;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fetch_pc <= PC_INIT;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (misprediction) begin
      // Redirect wins over any same-cycle response or pop.
      r_fetch_pc <= correct_pc;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= pc_prediction;
      end
      if (w_wr) begin
        r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
        r_instr_mem[r_wr_ptr] <= imemload;
        r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_wr && !w_rd) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_wr && w_rd) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  logic w_unused;
  assign w_unused = w_bypass;

endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
// Scoreboard bench for fetch_queue: expected entries are queued when a response is
// driven and compared when the queue presents them to decode.
module tb_fetch_queue;

  localparam int          DEPTH   = 4;
  localparam logic [31:0] PC_INIT = 32'h100;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ihit;
  logic [31:0] imemload;
  logic [31:0] pc_prediction;
  logic        misprediction;
  logic [31:0] correct_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  fetch_queue #(
    .PC_W(32), .INSTR_W(32), .DEPTH(DEPTH), .PC_INIT(PC_INIT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .ihit(ihit), .imemload(imemload), .pc_prediction(pc_prediction),
    .misprediction(misprediction), .correct_pc(correct_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .count(count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] m_pc;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, compare just after, then advance the model.
  task automatic cycle(input logic ih, input logic rdy, input logic mis, input logic [31:0] cpc);
    logic req, push, byp, vld;
    ent_t e, h;
    @(negedge CLK);
    e.pc          = m_pc;
    e.instr       = $urandom;
    ihit          = ih;
    imemload      = e.instr;
    pc_prediction = (m_pc[4:2] == 3'b111) ? m_pc + 32'h40 : m_pc + 32'd4;
    misprediction = mis;
    correct_pc    = cpc;
    out_ready     = rdy;
    #1;
    req  = (sb.size() < DEPTH) || rdy;
    push = ih && req && !mis;
    byp  = 1'b0;
`ifdef FETCH_BYPASS_EN
    byp  = (sb.size() == 0) && push;
`endif
    vld  = (sb.size() != 0) || byp;
    check("imem_req", imem_req, req);
    check("imem_addr", imem_addr, m_pc);
    check("count", count, sb.size());
    check("out_valid", out_valid, vld);
    if (vld) begin
      h = byp ? e : sb[0];
      check("out_pc", out_pc, h.pc);
      check("out_instr", out_instr, h.instr);
    end
    if (mis) begin
      sb.delete();
      m_pc = cpc;
    end else begin
      if (vld && rdy && !byp) void'(sb.pop_front());
      if (push && !(byp && rdy)) sb.push_back(e);
      if (push) m_pc = pc_prediction;
    end
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; imemload = '0; pc_prediction = '0;
    misprediction = 1'b0; correct_pc = '0; out_ready = 1'b0;
    m_pc = PC_INIT;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_count", count, 0);
    check("rst_pc", out_pc, 0);
    check("rst_instr", out_instr, 0);
    check("rst_req", imem_req, 1'b1);
    check("rst_addr", imem_addr, PC_INIT);
    #1 RST = 1'b0;

    // Streaming with decode always ready.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, '0);

    // Decode stalls until full, then one combined pop/push.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, '0);
    check("full_count", count, 4);
    check("full_req", imem_req, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check("full_keep", count, 4);

    // Redirect while full with a live response.
    cycle(1'b1, 1'b1, 1'b1, 32'h200);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check("redir_count", count, 0);
    check("redir_valid", out_valid, 1'b0);
    check("redir_addr", imem_addr, 32'h200);

    // Redirect with two entries and a same-cycle response.
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b1, 32'h300);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check("redir2_count", count, 0);
    check("redir2_addr", imem_addr, 32'h300);

    // Continuous traffic across several pointer wraps, then mixed traffic.
    for (int i = 0; i < 3 * DEPTH + 2; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0), 32'h1000 + ($urandom_range(0, 255) << 2));
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b1, 1'b0, '0);

    // Asynchronous reset with three buffered entries.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, '0);
    @(negedge CLK);
    ihit = 1'b0; out_ready = 1'b0; misprediction = 1'b0;
    #1;
    check("pre_rst_count", count, 3);
    #1 RST = 1'b1;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_count", count, 0);
    check("arst_addr", imem_addr, PC_INIT);
    sb.delete();
    m_pc = PC_INIT;
    #1 RST = 1'b0;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised successor to the single-register fetch stage. Holds the fetch PC, issues instruction-memory requests, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Decode drains the FIFO through a valid/ready handshake, so decode stalls no longer freeze the PC directly. Sits between the branch predictor and imem on one side and decode on the other; a misprediction redirect flushes the buffer in one cycle.

## Interface
- PC_INIT, 0: fetch PC after reset.
- PC_W, 32: PC width.
- INSTR_W, 32: instruction width.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; high when the FIFO can accept a response this cycle.
- imem_addr  out  PC_W  current fetch PC.
- ihit  in  1  imem response valid this cycle; only meaningful while imem_req is high.
- imemload  in  INSTR_W  instruction returned for imem_addr.
- pc_prediction  in  PC_W  predicted next PC for imem_addr (combinational from the predictor).
- misprediction  in  1  redirect strobe from execute.
- correct_pc  in  PC_W  redirect target.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode accepts the head entry.
- out_pc  out  PC_W  PC of the head entry.
- out_instr  out  INSTR_W  instruction of the head entry.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- State: fetch_pc, rd_ptr, wr_ptr, count, and DEPTH entries of {pc, instr}.
- pop = out_valid && out_ready.
- push = ihit && imem_req && !misprediction.
- imem_req = (count < DEPTH) || out_ready. A full FIFO still accepts a push when a pop occurs in the same cycle.
- imem_addr = fetch_pc.
- On push:
  - Write {fetch_pc, imemload} at wr_ptr.
  - wr_ptr advances modulo DEPTH.
  - fetch_pc <= pc_prediction.
- On pop: rd_ptr advances modulo DEPTH.
- count += push - pop; a simultaneous push and pop leaves count unchanged.
- count never exceeds DEPTH. A push while full without a pop cannot occur because imem_req is low.
- Pop while empty is ignored; out_valid is low.
- Redirect (misprediction high) has priority over everything:
  - fetch_pc <= correct_pc.
  - rd_ptr, wr_ptr and count <= 0.
  - Any same-cycle ihit response is discarded and the pop is ignored.
- Pointers wrap naturally because DEPTH is a power of two.
- out_pc and out_instr present the entry at rd_ptr. Their value is don't-care while out_valid is low, except at reset.

## Timing
- Reset (RST high, asynchronous):
  - fetch_pc = PC_INIT; rd_ptr, wr_ptr, count = 0; all entries cleared to 0.
  - out_valid = 0, out_pc = 0, out_instr = 0, imem_req = 1, imem_addr = PC_INIT.
- Reset asserted mid-operation discards all buffered entries immediately, without waiting for a clock edge.
- Without bypass, an instruction returned in cycle N is visible on out_* in cycle N+1.
- Redirect in cycle N:
  - imem_addr = correct_pc and out_valid = 0 in cycle N+1.
  - The first redirected instruction can appear at the output in cycle N+2, or N+1 with bypass.
- Throughput: one instruction per cycle when ihit is continuous and out_ready is continuous.

## Configuration
- FETCH_BYPASS_EN defined:
  - When count == 0 and push occurs, out_valid = 1 in the same cycle, with out_pc = fetch_pc and out_instr = imemload.
  - If out_ready is also high, the entry is consumed and not written; count stays 0.
  - If out_ready is low, the entry is written normally.
- FETCH_BYPASS_EN undefined:
  - No combinational path from imemload or ihit to out_*.
  - Output latency is always at least one cycle.

## Test plan
- Reset, PC_INIT=0x100, ihit=1 every cycle, pc_prediction=imem_addr+4, out_ready=1 -> out_pc sequence 0x100, 0x104, 0x108 from cycle 1 (cycle 0 with bypass); count stays at most 1.
- out_ready=0 with continuous ihit -> count rises to 4 and imem_req drops to 0. Then out_ready=1 for one cycle -> pop and push occur together, count stays 4, and entries come out in FIFO order.
- FIFO full (count=4) and misprediction=1 with correct_pc=0x200 -> next cycle count=0, out_valid=0, imem_addr=0x200. The same-cycle ihit data never reaches the output.
- ihit and misprediction in the same cycle with count=2 -> response dropped, count=0, fetch_pc=correct_pc.
- Continuous push/pop for 3*DEPTH cycles -> pointers wrap with no lost or duplicated PCs, checked against a scoreboard.
- RST asserted asynchronously with count=3 -> out_valid=0 and count=0 before the next CLK edge, and imem_addr=PC_INIT.
